// File: rtl/alu_sliced_pkg.sv
// Shared ALU types: command encoding, per-slice control, result flags and FSM states.
package alu_sliced_pkg;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_COMP, ALU_AND, ALU_OR, ALU_XOR, ALU_XNOR, ALU_RSHFT
  } alu_cmd_t;

  typedef struct packed {
    logic     b_inv;
    logic     cin;
    alu_cmd_t cmd;
  } alu_slice_ctrl_t;

  typedef struct packed {
    logic carry_out;
    logic zero;
    logic all_ones;
  } alu_flags_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} alu_state_t;

  function automatic logic is_arith(alu_cmd_t cmd);
    return (cmd == ALU_ADD) || (cmd == ALU_SUB) || (cmd == ALU_COMP);
  endfunction

  // SUB and COMP override the caller's invert/carry; logic ops never use a carry.
  function automatic alu_slice_ctrl_t eff_ctrl(alu_cmd_t cmd, logic b_inv, logic carry_in);
    alu_slice_ctrl_t c;
    c.cmd   = cmd;
    c.b_inv = b_inv;
    c.cin   = 1'b0;
    case (cmd)
      ALU_ADD:   c.cin = carry_in;
      ALU_SUB:   begin c.b_inv = 1'b1; c.cin = 1'b1; end
      ALU_COMP:  begin c.b_inv = 1'b1; c.cin = 1'b0; end
      ALU_RSHFT: c.cin = carry_in;
      default:   c.cin = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_sliced_if.sv
// Operand/result handshake bundle between operand fetch, the sliced ALU and writeback.
interface alu_sliced_if
  import alu_sliced_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  alu_cmd_t          cmd;
  logic              b_inv;
  logic              carry_in;
  logic              carry_disable;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] res;
  logic              carry_out;
  logic              zero;
  logic              all_ones;

  modport master (
    output in_valid, cmd, b_inv, carry_in, carry_disable, d1, d2, out_ready,
    input  in_ready, out_valid, res, carry_out, zero, all_ones
  );

  modport slave (
    input  in_valid, cmd, b_inv, carry_in, carry_disable, d1, d2, out_ready,
    output in_ready, out_valid, res, carry_out, zero, all_ones
  );
endinterface

// File: rtl/alu_slice.sv
// Combinational SLICE_W-bit ALU datapath; in lane mode the slice takes its own carry from ctrl.
module alu_slice
  import alu_sliced_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic               lane,
  input  alu_slice_ctrl_t    ctrl,
  output logic [SLICE_W-1:0] res,
  output logic               cout
);
  logic [SLICE_W-1:0] bb;
  logic               c;
  logic [SLICE_W:0]   sum;
  logic [SLICE_W:0]   shifted;

  assign bb      = ctrl.b_inv ? ~b : b;
  assign c       = lane ? ctrl.cin : cin;
  assign sum     = {1'b0, a} + {1'b0, bb} + {{SLICE_W{1'b0}}, c};
  assign shifted = {c, bb};

  always_comb begin
    res  = sum[SLICE_W-1:0];
    cout = 1'b0;
    case (ctrl.cmd)
      ALU_ADD, ALU_SUB, ALU_COMP: begin
        res  = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      ALU_AND:  res = a & bb;
      ALU_OR:   res = a | bb;
      ALU_XOR:  res = a ^ bb;
      ALU_XNOR: res = ~(a ^ bb);
      // The LSB leaving this slice is the bit entering the slice below.
      ALU_RSHFT: begin
        res  = shifted[SLICE_W:1];
        cout = bb[0];
      end
      default: res = sum[SLICE_W-1:0];
    endcase
  end
endmodule

// File: rtl/alu_sliced.sv
// Multi-cycle ALU: one slice per clock through a shared alu_slice, carry held between slices.
module alu_sliced
  import alu_sliced_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input logic         clk,
  input logic         rst,
  alu_sliced_if.slave bus
);
  localparam int NSLICES = DATA_W / SLICE_W;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0]  LAST       = IDX_W'(NSLICES - 1);
  localparam logic [DATA_W-1:0] SLICE_MASK = DATA_W'({SLICE_W{1'b1}});

  if (SLICE_W < 1 || NSLICES < 1 || (DATA_W % SLICE_W) != 0) begin : g_bad_width
    $error("alu_sliced: DATA_W must be a non-zero multiple of SLICE_W");
  end

  alu_state_t        state, state_next;
  logic [IDX_W-1:0]  idx, pos;
  alu_slice_ctrl_t   ctrl_r, acc_ctrl;
  logic              lane_r, carry_r, zero_acc, ones_acc;
  logic [DATA_W-1:0] d1_r, d2_r, work_r, work_next, res_r;
  alu_flags_t        flags_r;
  logic              accept, last, carry_final;
  logic [31:0]       sh;
  logic [SLICE_W-1:0] a_s, b_s, res_s;
  logic              cout_s;

  assign bus.in_ready = !rst && (state == ST_IDLE || (state == ST_DONE && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;
  assign acc_ctrl     = eff_ctrl(bus.cmd, bus.b_inv, bus.carry_in);
  assign last         = (idx == LAST);

  // Shifts walk from the top slice down so the carry register carries the shifted-out bit.
  assign pos       = (ctrl_r.cmd == ALU_RSHFT) ? LAST - idx : idx;
  assign sh        = 32'(pos) * SLICE_W;
  assign a_s       = SLICE_W'(d1_r >> sh);
  assign b_s       = SLICE_W'(d2_r >> sh);
  assign work_next = (work_r & ~(SLICE_MASK << sh)) | (DATA_W'(res_s) << sh);
  assign carry_final = is_arith(ctrl_r.cmd) && !lane_r && cout_s;

  alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (a_s),
    .b    (b_s),
    .cin  (carry_r),
    .lane (lane_r),
    .ctrl (ctrl_r),
    .res  (res_s),
    .cout (cout_s)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (last) state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = accept ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      res_r   <= '0;
      flags_r <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        idx     <= '0;
        carry_r <= acc_ctrl.cin;
      end else if (state == ST_RUN) begin
        idx     <= last ? '0 : idx + 1'b1;
        carry_r <= cout_s;
        if (last) begin
          res_r             <= work_next;
          flags_r.carry_out <= carry_final;
          flags_r.zero      <= zero_acc & ~|res_s;
          flags_r.all_ones  <= ones_acc & (&res_s);
        end
      end
    end
  end

  // Operand and accumulation registers need no reset: accept reinitialises them.
  always_ff @(posedge clk) begin
    if (accept) begin
      ctrl_r   <= acc_ctrl;
      lane_r   <= bus.carry_disable;
      d1_r     <= bus.d1;
      d2_r     <= bus.d2;
      zero_acc <= 1'b1;
      ones_acc <= 1'b1;
    end else if (state == ST_RUN) begin
      work_r   <= work_next;
      zero_acc <= zero_acc & ~|res_s;
      ones_acc <= ones_acc & (&res_s);
    end
  end

  assign bus.out_valid = (state == ST_DONE);
  assign bus.res       = res_r;
  assign bus.carry_out = flags_r.carry_out;
  assign bus.zero      = flags_r.zero;
  assign bus.all_ones  = flags_r.all_ones;
endmodule

// File: tb/tb_alu_sliced.sv
// Scoreboard bench for alu_sliced: directed cases, backpressure, reset abort and random traffic.
module tb_alu_sliced;
  import alu_sliced_pkg::*;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 16;
  localparam int NSLICES = DATA_W / SLICE_W;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              co;
    logic              z;
    logic              o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sliced_if #(.DATA_W(DATA_W)) bus ();

  alu_sliced #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  bit   seen_valid = 1'b0;
  int   bp_mode = 0;

  task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(logic [DATA_W-1:0] r, logic co, logic z, logic o);
    exp_t e;
    e.res = r; e.co = co; e.z = z; e.o = o;
    return e;
  endfunction

  // Reference: whole-word arithmetic, or independent lanes when carry_disable is set.
  function automatic exp_t model(alu_cmd_t c, logic bi, logic ci, logic cd,
                                 logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    logic [DATA_W-1:0]  bb, r;
    logic [DATA_W:0]    wide;
    logic [SLICE_W-1:0] al, bl;
    logic [SLICE_W:0]   ls;
    logic               co;
    bb = bi ? ~b : b;
    r  = '0;
    co = 1'b0;
    case (c)
      ALU_ADD:
        if (!cd) begin
          wide = {1'b0, a} + {1'b0, bb} + {{DATA_W{1'b0}}, ci};
          r = wide[DATA_W-1:0];
          co = wide[DATA_W];
        end else
          for (int l = 0; l < NSLICES; l++) begin
            ls = {1'b0, a[l*SLICE_W +: SLICE_W]} + {1'b0, bb[l*SLICE_W +: SLICE_W]}
                 + {{SLICE_W{1'b0}}, ci};
            r[l*SLICE_W +: SLICE_W] = ls[SLICE_W-1:0];
          end
      ALU_SUB:
        if (!cd) begin
          r = a - b;
          co = (a >= b);
        end else
          for (int l = 0; l < NSLICES; l++) begin
            al = a[l*SLICE_W +: SLICE_W];
            bl = b[l*SLICE_W +: SLICE_W];
            r[l*SLICE_W +: SLICE_W] = al - bl;
          end
      ALU_COMP:
        if (!cd) begin
          r = a + ~b;
          co = (a > b);
        end else
          for (int l = 0; l < NSLICES; l++) begin
            al = a[l*SLICE_W +: SLICE_W];
            bl = b[l*SLICE_W +: SLICE_W];
            r[l*SLICE_W +: SLICE_W] = al + ~bl;
          end
      ALU_AND:  r = a & bb;
      ALU_OR:   r = a | bb;
      ALU_XOR:  r = a ^ bb;
      ALU_XNOR: r = ~(a ^ bb);
      ALU_RSHFT:
        if (!cd) r = {ci, bb[DATA_W-1:1]};
        else
          for (int l = 0; l < NSLICES; l++) begin
            bl = bb[l*SLICE_W +: SLICE_W];
            r[l*SLICE_W +: SLICE_W] = {ci, bl[SLICE_W-1:1]};
          end
      default: r = '0;
    endcase
    return mk(r, co, (r == '0), (&r));
  endfunction

  always @(posedge clk) begin
    #2;
    case (bp_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: latency on first sight of out_valid, payload on each handshake.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst) begin
      exp_q.delete();
      lat_q.delete();
      seen_valid = 1'b0;
    end else begin
      if (bus.out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        if (lat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got out_valid=1, expected no pending operation");
        end else check("latency", DATA_W'(ncyc - lat_q.pop_front()), DATA_W'(NSLICES));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got res=%0h, expected nothing", bus.res);
        end else begin
          e = exp_q.pop_front();
          check("res", bus.res, e.res);
          check("carry_out", DATA_W'(bus.carry_out), DATA_W'(e.co));
          check("zero", DATA_W'(bus.zero), DATA_W'(e.z));
          check("all_ones", DATA_W'(bus.all_ones), DATA_W'(e.o));
        end
        seen_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) lat_q.push_back(ncyc + 1);
    end
  end

  task automatic issue(alu_cmd_t c, logic bi, logic ci, logic cd,
                       logic [DATA_W-1:0] a, logic [DATA_W-1:0] b, exp_t e, output int waits);
    bit done;
    bus.cmd = c; bus.b_inv = bi; bus.carry_in = ci; bus.carry_disable = cd;
    bus.d1 = a; bus.d2 = b; bus.in_valid = 1'b1;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 200) begin
          checks++; errors++;
          $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", waits);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", DATA_W'(exp_q.size()), '0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no finish, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    alu_cmd_t c;
    logic bi, ci, cd;
    logic [DATA_W-1:0] a, b;

    bus.in_valid = 1'b0; bus.cmd = ALU_ADD; bus.b_inv = 1'b0; bus.carry_in = 1'b0;
    bus.carry_disable = 1'b0; bus.d1 = '0; bus.d2 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_rst", DATA_W'(bus.in_ready), '0);
    check("out_valid_in_rst", DATA_W'(bus.out_valid), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", DATA_W'(bus.in_ready), DATA_W'(1));
    check("rst_res", bus.res, '0);
    check("rst_flags", DATA_W'({bus.carry_out, bus.zero, bus.all_ones, bus.out_valid}), '0);
    @(posedge clk); #1;

    issue(ALU_ADD,  0, 0, 0, 32'h0000FFFF, 32'h00000001, mk(32'h00010000, 0, 0, 0), w);
    issue(ALU_SUB,  0, 0, 0, 32'h00000000, 32'h00000001, mk(32'hFFFFFFFF, 0, 0, 1), w);
    issue(ALU_SUB,  0, 0, 0, 32'h00000005, 32'h00000005, mk(32'h00000000, 1, 1, 0), w);
    issue(ALU_COMP, 0, 0, 0, 32'h10000000, 32'h0FFFFFFF, mk(32'h00000000, 1, 1, 0), w);
    issue(ALU_COMP, 0, 0, 0, 32'h12345678, 32'h12345678, mk(32'hFFFFFFFF, 0, 0, 1), w);
    issue(ALU_RSHFT, 0, 1, 0, 32'h00000000, 32'h00010000, mk(32'h80008000, 0, 0, 0), w);
    issue(ALU_RSHFT, 0, 1, 1, 32'h00000000, 32'h00010000, mk(32'h80008000, 0, 0, 0), w);
    issue(ALU_ADD,  0, 0, 1, 32'h0001FFFF, 32'h00010001, mk(32'h00020000, 0, 0, 0), w);
    issue(ALU_XNOR, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'hF00FF00F, 0, 0, 0), w);
    issue(ALU_ADD,  1, 1, 0, 32'h12345678, 32'h00000001, mk(32'h12345677, 1, 0, 0), w);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    bp_mode = 1;
    issue(ALU_ADD, 0, 0, 0, 32'h00000001, 32'h00000002, mk(32'h00000003, 0, 0, 0), w);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_res_stable", bus.res, 32'h00000003);
      check("bp_in_ready", DATA_W'(bus.in_ready), '0);
      check("bp_out_valid", DATA_W'(bus.out_valid), DATA_W'(1));
    end
    @(posedge clk); #1;
    bp_mode = 0;
    issue(ALU_AND, 0, 0, 0, 32'hFFFF0000, 32'h0F0F0F0F, mk(32'h0F0F0000, 0, 0, 0), w);
    check("same_cycle_accept_waits", DATA_W'(w), '0);
    drain();

    // Reset in the first RUN cycle aborts the operation.
    issue(ALU_ADD, 0, 0, 0, 32'h00000007, 32'h00000008, mk(32'h0000000F, 0, 0, 0), w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", DATA_W'(bus.out_valid), '0);
    check("abort_res", bus.res, '0);
    check("abort_flags", DATA_W'({bus.carry_out, bus.zero, bus.all_ones}), '0);
    check("abort_in_ready", DATA_W'(bus.in_ready), DATA_W'(1));
    repeat (4) begin
      @(negedge clk);
      check("abort_no_result", DATA_W'(bus.out_valid), '0);
    end
    @(posedge clk); #1;

    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      c  = alu_cmd_t'(3'($urandom_range(0, 7)));
      bi = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      cd = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 4))
        0: b = a;
        1: begin a = '1; b = 32'($urandom_range(0, 2)); end
        2: begin a = 32'($urandom_range(0, 3)); b = 32'h0000FFFF; end
        default: ;
      endcase
      issue(c, bi, ci, cd, a, b, model(c, bi, ci, cd, a, b), w);
      bus.d1 = $urandom;
      bus.d2 = $urandom;
      bus.cmd = alu_cmd_t'(3'($urandom_range(0, 7)));
      n = $urandom_range(0, 2);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    end
    bp_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
